// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: double-buffered FIR coefficient store. Software writes the
// shadow bank through a level-based 4-phase handshake, arms a commit, and the
// banks swap at the next video frame start. Every frame, the active bank is
// streamed out to the convolution engine one coefficient per cycle.
module fir_coeff_ctrl #(
  parameter int N_COEFF = 25,
  parameter int COEFF_W = 16,
  parameter bit POL_VS  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vs_i,
  input  logic [7:0]         axi_addr_i,
  input  logic [31:0]        axi_data_i,
  input  logic               axi_wr_strobe_i,
  output logic               axi_wr_ack_o,
  input  logic               axi_rd_strobe_i,
  output logic               axi_rd_ack_o,
  output logic [31:0]        axi_rdata_o,
  output logic [COEFF_W-1:0] coeff_o,
  output logic [4:0]         coeff_idx_o,
  output logic               coeff_valid_o,
  output logic               busy_o
);

  localparam int                 IDX_W      = $clog2(N_COEFF);
  localparam logic [5:0]         N_IDX      = 6'(N_COEFF);
  localparam logic [4:0]         LAST_IDX   = 5'(N_COEFF - 1);
  localparam logic [COEFF_W-1:0] CENTER_VAL = COEFF_W'(16'h0100);

  typedef enum logic [1:0] {
    IDLE,
    SWAP,
    STREAM
  } state_t;

  state_t             state;
  logic               bank_sel;
  logic               pending;
  logic [COEFF_W-1:0] bank [2][N_COEFF];

  logic [1:0]  wr_sync;
  logic [1:0]  rd_sync;
  logic        wr_prev;
  logic        rd_prev;
  logic        wr_req;
  logic        rd_req;
  logic [5:0]  word_idx;
  logic        shadow_sel;
  logic        commit_req;
  logic [31:0] rd_value;
  logic [4:0]  next_idx;

  logic        vs_c;
  logic        vs_d;
  logic        frame_start;

  logic        unused_bits;

  assign word_idx    = axi_addr_i[7:2];
  assign wr_req      = wr_sync[1] & ~wr_prev;
  assign rd_req      = rd_sync[1] & ~rd_prev;
  assign vs_c        = POL_VS ? vs_i : ~vs_i;
  assign frame_start = vs_c & ~vs_d;
  assign commit_req  = wr_req && (word_idx == N_IDX) && axi_data_i[0];
  assign next_idx    = coeff_idx_o + 5'd1;
  assign busy_o      = (state == STREAM);
  assign unused_bits = ^{axi_addr_i[1:0], axi_data_i[31:COEFF_W]};

  // During the swap cycle bank_sel has not flipped yet, so the bank that is
  // about to become shadow is the one bank_sel currently names.
  assign shadow_sel = (state == SWAP) ? bank_sel : ~bank_sel;

  // Read mux: active coefficients, then the status word, then zeros.
  always_comb begin
    rd_value = '0;
    if (word_idx < N_IDX) begin
      rd_value = 32'(bank[bank_sel][word_idx[IDX_W-1:0]]);
    end else if (word_idx == N_IDX) begin
      rd_value = {30'd0, bank_sel, pending};
    end
  end

  // Strobe synchronizers, edge history and the acknowledge levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sync      <= '0;
      rd_sync      <= '0;
      wr_prev      <= 1'b0;
      rd_prev      <= 1'b0;
      axi_wr_ack_o <= 1'b0;
      axi_rd_ack_o <= 1'b0;
      vs_d         <= 1'b0;
    end else begin
      wr_sync <= {wr_sync[0], axi_wr_strobe_i};
      rd_sync <= {rd_sync[0], axi_rd_strobe_i};
      wr_prev <= wr_sync[1];
      rd_prev <= rd_sync[1];
      vs_d    <= vs_c;
      if (!wr_sync[1]) begin
        axi_wr_ack_o <= 1'b0;
      end else if (wr_req) begin
        axi_wr_ack_o <= 1'b1;
      end
      if (!rd_sync[1]) begin
        axi_rd_ack_o <= 1'b0;
      end else if (rd_req) begin
        axi_rd_ack_o <= 1'b1;
      end
    end
  end

  // Read data is captured once per request and held until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      axi_rdata_o <= '0;
    end else if (rd_req) begin
      axi_rdata_o <= rd_value;
    end
  end

  // Coefficient banks: reset to a unity-gain centre tap, writes go to shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_COEFF; i++) begin
          bank[b][i] <= (i == N_COEFF / 2) ? CENTER_VAL : '0;
        end
      end
    end else if (wr_req && (word_idx < N_IDX)) begin
      bank[shadow_sel][word_idx[IDX_W-1:0]] <= axi_data_i[COEFF_W-1:0];
    end
  end

  // Frame FSM: optional bank swap, then one pass over the active bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bank_sel      <= 1'b0;
      pending       <= 1'b0;
      coeff_valid_o <= 1'b0;
      coeff_idx_o   <= '0;
      coeff_o       <= '0;
    end else begin
      case (state)
        IDLE: begin
          coeff_valid_o <= 1'b0;
          coeff_idx_o   <= '0;
          coeff_o       <= '0;
          if (frame_start) begin
            if (pending) begin
              state <= SWAP;
            end else begin
              state         <= STREAM;
              coeff_valid_o <= 1'b1;
              coeff_o       <= bank[bank_sel][0];
            end
          end
        end
        SWAP: begin
          bank_sel      <= ~bank_sel;
          pending       <= 1'b0;
          state         <= STREAM;
          coeff_valid_o <= 1'b1;
          coeff_idx_o   <= '0;
          coeff_o       <= bank[~bank_sel][0];
        end
        STREAM: begin
          if (coeff_idx_o == LAST_IDX) begin
            state         <= IDLE;
            coeff_valid_o <= 1'b0;
            coeff_idx_o   <= '0;
            coeff_o       <= '0;
          end else begin
            coeff_idx_o <= next_idx;
            coeff_o     <= bank[bank_sel][next_idx[IDX_W-1:0]];
          end
        end
        default: begin
          state         <= IDLE;
          coeff_valid_o <= 1'b0;
          coeff_idx_o   <= '0;
          coeff_o       <= '0;
        end
      endcase
      if (commit_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl: directed bench for fir_coeff_ctrl with a frame-level
// reference model of the two banks, the commit flag and the streamed output.
module tb_fir_coeff_ctrl;

  localparam int N_COEFF = 25;
  localparam int COEFF_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               vs_i = 1'b0;
  logic [7:0]         axi_addr_i = '0;
  logic [31:0]        axi_data_i = '0;
  logic               axi_wr_strobe_i = 1'b0;
  logic               axi_wr_ack_o;
  logic               axi_rd_strobe_i = 1'b0;
  logic               axi_rd_ack_o;
  logic [31:0]        axi_rdata_o;
  logic [COEFF_W-1:0] coeff_o;
  logic [4:0]         coeff_idx_o;
  logic               coeff_valid_o;
  logic               busy_o;

  fir_coeff_ctrl #(
    .N_COEFF (N_COEFF),
    .COEFF_W (COEFF_W),
    .POL_VS  (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .vs_i            (vs_i),
    .axi_addr_i      (axi_addr_i),
    .axi_data_i      (axi_data_i),
    .axi_wr_strobe_i (axi_wr_strobe_i),
    .axi_wr_ack_o    (axi_wr_ack_o),
    .axi_rd_strobe_i (axi_rd_strobe_i),
    .axi_rd_ack_o    (axi_rd_ack_o),
    .axi_rdata_o     (axi_rdata_o),
    .coeff_o         (coeff_o),
    .coeff_idx_o     (coeff_idx_o),
    .coeff_valid_o   (coeff_valid_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        valid;
    logic [4:0]  idx;
    logic [15:0] coeff;
  } out_t;

  typedef struct {
    int unsigned at;
    int          idx;
    logic [31:0] data;
  } wr_ev_t;

  out_t        exp_q[$];
  wr_ev_t      wr_q[$];
  logic [15:0] m_bank [2][N_COEFF];
  logic        m_sel;
  logic        m_pending;
  logic        m_vs_prev;
  int unsigned cyc = 0;
  int unsigned idle_from = 0;

  int          vec_count = 0;
  int          miscompares = 0;
  int          valid_seen = 0;
  int          busy_seen = 0;
  logic [31:0] seen_coeff [32];
  logic [31:0] rdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N_COEFF; i++) begin
        m_bank[b][i] = (i == N_COEFF / 2) ? 16'h0100 : 16'h0000;
      end
    end
    m_sel     = 1'b0;
    m_pending = 1'b0;
    m_vs_prev = 1'b0;
    idle_from = 0;
    exp_q.delete();
    wr_q.delete();
  endtask

  // Frame-level model: at each edge decide on frame acceptance using the
  // pre-edge commit flag, apply writes due now, then queue the whole frame.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      modelReset();
    end else begin
      logic   fs;
      logic   accept;
      logic   do_swap;
      wr_ev_t ev;
      cyc++;
      fs        = vs_i && !m_vs_prev;
      m_vs_prev = vs_i;
      accept    = fs && (cyc >= idle_from);
      do_swap   = accept && m_pending;
      while (wr_q.size() > 0 && wr_q[0].at <= cyc) begin
        ev = wr_q.pop_front();
        if (ev.idx < N_COEFF) begin
          m_bank[!m_sel][ev.idx] = ev.data[15:0];
        end else if (ev.idx == N_COEFF && ev.data[0]) begin
          m_pending = 1'b1;
        end
      end
      if (accept) begin
        if (do_swap) begin
          exp_q.push_back('0);
          m_sel     = !m_sel;
          m_pending = 1'b0;
        end
        for (int i = 0; i < N_COEFF; i++) begin
          exp_q.push_back('{busy: 1'b1, valid: 1'b1, idx: 5'(i), coeff: m_bank[m_sel][i]});
        end
        idle_from = cyc + exp_q.size() + 1;
      end
    end
  end

  // Cycle-by-cycle comparison of the stream interface against the model.
  always @(negedge clk) begin
    if (rst) begin
      out_t exp_o;
      out_t act_o;
      exp_o = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      act_o = {busy_o, coeff_valid_o, coeff_idx_o, coeff_o};
      checkOutput("stream_out", 32'(act_o), 32'(exp_o));
      if (coeff_valid_o) begin
        valid_seen++;
        seen_coeff[coeff_idx_o] = 32'(coeff_o);
      end
      if (busy_o) begin
        busy_seen++;
      end
    end
  end

  // Full 4-phase transaction; expects to be entered just after a falling edge.
  task automatic applyStimulus(input bit is_wr, input logic [7:0] addr, input logic [31:0] data,
                               input int hold, output logic [31:0] rd);
    axi_addr_i = addr;
    axi_data_i = data;
    if (is_wr) begin
      axi_wr_strobe_i = 1'b1;
      wr_q.push_back('{cyc + 3, int'(addr[7:2]), data});
    end else begin
      axi_rd_strobe_i = 1'b1;
    end
    for (int n = 1; n <= hold; n++) begin
      @(negedge clk);
      checkOutput(is_wr ? "wr_ack_high" : "rd_ack_high",
                  32'(is_wr ? axi_wr_ack_o : axi_rd_ack_o), 32'(n >= 3));
    end
    axi_wr_strobe_i = 1'b0;
    axi_rd_strobe_i = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checkOutput(is_wr ? "wr_ack_low" : "rd_ack_low",
                  32'(is_wr ? axi_wr_ack_o : axi_rd_ack_o), 32'(n < 3));
    end
    rd = axi_rdata_o;
  endtask

  task automatic vsPulse();
    vs_i = 1'b1;
    @(negedge clk);
    vs_i = 1'b0;
  endtask

  task automatic clearSeen();
    valid_seen = 0;
    busy_seen  = 0;
    for (int i = 0; i < 32; i++) begin
      seen_coeff[i] = 32'hFFFF_FFFF;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    clearSeen();
    repeat (3) @(negedge clk);
    checkOutput("reset_outs",
                32'({axi_wr_ack_o, axi_rd_ack_o, busy_o, coeff_valid_o, coeff_idx_o, coeff_o}), 32'd0);
    checkOutput("reset_rdata", axi_rdata_o, 32'd0);
    checkOutput("model_center_tap", 32'(m_bank[0][12]), 32'h0000_0100);
    #2 rst = 1'b1;
    @(negedge clk);

    $display("[TB] reset-value frame");
    clearSeen();
    vsPulse();
    repeat (30) @(negedge clk);
    checkOutput("rst_frame_valid_count", 32'(valid_seen), 32'd25);
    checkOutput("rst_frame_busy_count", 32'(busy_seen), 32'd25);
    checkOutput("rst_frame_idx12", seen_coeff[12], 32'h0000_0100);
    checkOutput("rst_frame_idx0", seen_coeff[0], 32'h0000_0000);

    $display("[TB] shadow write then commit");
    applyStimulus(1'b1, 8'h0C, 32'h0000_1234, 4, rdata);
    clearSeen();
    vsPulse();
    repeat (30) @(negedge clk);
    checkOutput("pre_commit_idx3", seen_coeff[3], 32'h0000_0000);
    applyStimulus(1'b1, 8'h64, 32'h0000_0001, 4, rdata);
    applyStimulus(1'b0, 8'h64, 32'h0, 4, rdata);
    checkOutput("status_pending", rdata, 32'h0000_0001);
    clearSeen();
    vsPulse();
    repeat (30) @(negedge clk);
    checkOutput("post_swap_idx3", seen_coeff[3], 32'h0000_1234);
    checkOutput("post_swap_valid_count", 32'(valid_seen), 32'd25);
    applyStimulus(1'b0, 8'h64, 32'h0, 4, rdata);
    checkOutput("status_swapped", rdata, 32'h0000_0002);
    checkOutput("status_model", rdata, {30'd0, m_sel, m_pending});
    applyStimulus(1'b0, 8'h0C, 32'h0, 4, rdata);
    checkOutput("read_active_idx3", rdata, 32'h0000_1234);

    $display("[TB] commit coinciding with frame start");
    applyStimulus(1'b1, 8'h14, 32'h0000_BEEF, 4, rdata);
    clearSeen();
    fork
      applyStimulus(1'b1, 8'h64, 32'h0000_0001, 4, rdata);
      begin
        @(negedge clk);
        @(negedge clk);
        vsPulse();
      end
    join
    repeat (30) @(negedge clk);
    checkOutput("same_cycle_old_idx5", seen_coeff[5], 32'h0000_0000);
    checkOutput("same_cycle_old_idx3", seen_coeff[3], 32'h0000_1234);
    applyStimulus(1'b0, 8'h64, 32'h0, 4, rdata);
    checkOutput("status_sel1_pend1", rdata, 32'h0000_0003);
    clearSeen();
    vsPulse();
    repeat (30) @(negedge clk);
    checkOutput("next_frame_idx5", seen_coeff[5], 32'h0000_BEEF);
    checkOutput("next_frame_idx3", seen_coeff[3], 32'h0000_0000);
    applyStimulus(1'b0, 8'h64, 32'h0, 4, rdata);
    checkOutput("status_sel0_pend0", rdata, 32'h0000_0000);

    $display("[TB] frame start during stream");
    clearSeen();
    vsPulse();
    repeat (9) @(negedge clk);
    vsPulse();
    repeat (35) @(negedge clk);
    checkOutput("no_restart_valid_count", 32'(valid_seen), 32'd25);

    $display("[TB] long strobes and out-of-range address");
    applyStimulus(1'b1, 8'hFC, 32'hFFFF_FFFF, 20, rdata);
    applyStimulus(1'b0, 8'hFC, 32'h0, 20, rdata);
    checkOutput("read_out_of_range", rdata, 32'h0000_0000);
    applyStimulus(1'b0, 8'h64, 32'h0, 20, rdata);
    checkOutput("status_unchanged", rdata, 32'h0000_0000);

    $display("[TB] reset during stream");
    applyStimulus(1'b1, 8'h64, 32'h0000_0001, 4, rdata);
    vsPulse();
    repeat (30) @(negedge clk);
    applyStimulus(1'b0, 8'h64, 32'h0, 4, rdata);
    checkOutput("status_before_abort", rdata, 32'h0000_0002);
    vsPulse();
    repeat (7) @(negedge clk);
    checkOutput("mid_stream_idx", 32'(coeff_idx_o), 32'd7);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_abort", 32'({busy_o, coeff_valid_o, coeff_idx_o, coeff_o}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 8'h64, 32'h0, 4, rdata);
    checkOutput("status_after_abort", rdata, 32'h0000_0000);
    applyStimulus(1'b0, 8'h30, 32'h0, 4, rdata);
    checkOutput("read_idx12_after_abort", rdata, 32'h0000_0100);
    clearSeen();
    vsPulse();
    repeat (30) @(negedge clk);
    checkOutput("abort_frame_idx3", seen_coeff[3], 32'h0000_0000);
    checkOutput("abort_frame_idx12", seen_coeff[12], 32'h0000_0100);
    checkOutput("abort_frame_valid_count", 32'(valid_seen), 32'd25);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 Parameter N_COEFF, default 25, number of convolution coefficients.
REQ-002 Parameter COEFF_W, default 16, coefficient width in bits.
REQ-003 Parameter POL_VS, default 1, vs_i polarity (1 = active-high, 0 = inverted internally).
REQ-004 clk  input  1  single clock; every register is clocked on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 vs_i  input  1  video vertical sync (polarity per POL_VS).
REQ-007 axi_addr_i  input  8  byte address; word index = axi_addr_i[7:2].
REQ-008 axi_data_i  input  32  write data.
REQ-009 axi_wr_strobe_i  input  1  write request level from the AXI clock domain.
REQ-010 axi_wr_ack_o  output  1  write acknowledge level.
REQ-011 axi_rd_strobe_i  input  1  read request level from the AXI clock domain.
REQ-012 axi_rd_ack_o  output  1  read acknowledge level.
REQ-013 axi_rdata_o  output  32  read data, valid while axi_rd_ack_o=1.
REQ-014 coeff_o  output  COEFF_W  streamed coefficient to the convolution.
REQ-015 coeff_idx_o  output  5  index of coeff_o.
REQ-016 coeff_valid_o  output  1  coeff_o/coeff_idx_o valid.
REQ-017 busy_o  output  1  high while STREAM state.

Function
REQ-018 Two coefficient banks (A, B) of N_COEFF x COEFF_W; a bank-select bit names the active bank, the other is shadow.
REQ-019 Each strobe passes a 2-FF synchronizer; a request is the synced 0->1 edge.
REQ-020 4-phase handshake: ack rises 1 cycle after request edge and falls 1 cycle after synced strobe reads 0.
REQ-021 Write index 0..N_COEFF-1: shadow[index] <= axi_data_i[COEFF_W-1:0] on the request-edge cycle.
REQ-022 Write index N_COEFF (commit): if axi_data_i[0]=1, set pending; data[0]=0 leaves pending unchanged.
REQ-023 Writes to any other index are ignored but acked.
REQ-024 Read index 0..N_COEFF-1 returns active[index], zero-extended; index N_COEFF returns {30'b0, bank_sel, pending}; other indices return 0.
REQ-025 axi_rdata_o is captured on the request-edge cycle and held until the next read.
REQ-026 Frame start = rising edge of polarity-corrected vs_i, detected against a 1-cycle registered copy.
REQ-027 FSM states: IDLE, SWAP, STREAM.
REQ-028 IDLE -> SWAP on frame start if pending=1; IDLE -> STREAM on frame start if pending=0.
REQ-029 SWAP (1 cycle): toggle bank_sel, clear pending, -> STREAM.
REQ-030 STREAM: counter 0..N_COEFF-1; each cycle coeff_valid_o=1, coeff_idx_o=counter, coeff_o=active[counter]; after index N_COEFF-1 -> IDLE.
REQ-031 Latency: first coeff_valid_o 1 cycle after frame start (no swap) or 2 cycles (swap); exactly N_COEFF consecutive valid cycles.
REQ-032 Frame starts during SWAP/STREAM are ignored; stream is never restarted or truncated.
REQ-033 Commit in the same cycle as a frame start: pending is sampled before the write; swap occurs next frame.
REQ-034 Commit while pending=1: no effect beyond keeping pending=1.
REQ-035 Shadow writes during STREAM are accepted; streamed data comes only from the active bank.
REQ-036 After a swap the new shadow holds the previous active contents (no copy); software rewrites as needed.
REQ-037 A request edge in the SWAP cycle targets the shadow as defined after the toggle.
REQ-038 Outside STREAM: coeff_valid_o=0, coeff_idx_o=0, coeff_o=0.

Reset
REQ-039 On rst=0 immediately: state IDLE, bank_sel=0 (A active), pending=0, counter=0, synchronizers 0.
REQ-040 All outputs 0 during and after reset until stimulated.
REQ-041 Both banks reset to 0 except index N_COEFF/2 (12) = 16'h0100.
REQ-042 Reset mid-STREAM aborts the stream; coeff_valid_o drops asynchronously.

Verification
REQ-043 Reset, no writes, vs pulse -> 25 valid cycles, idx 0..24, coeff 0 except idx12=16'h0100, busy_o high 25 cycles.
REQ-044 Write idx3 (addr 0x0C) = 0x1234, vs pulse -> streamed idx3 still 0; write addr 0x64 data 1, vs pulse -> SWAP then idx3=0x1234, status read shows bank_sel=1, pending=0.
REQ-045 Commit issued on the frame-start cycle -> stream uses old bank; next frame uses new bank.
REQ-046 Second vs edge at stream cycle 10 -> stream completes all 25 entries, no restart.
REQ-047 Strobe held high 20 cycles -> exactly one write/read, ack high until 1 cycle after synced strobe low; write addr 0xFC -> acked, no state change.
REQ-048 rst=0 at stream cycle 7 -> coeff_valid_o=0 at once, bank_sel=0, banks at reset values.
